// File: rtl/dma_pkg.sv
// Shared types and constants for the data-memory DMA engine.
package dma_pkg;

  localparam int unsigned WORD_BYTES = 3;
  // Range arithmetic width: a 24-bit base plus 3*Count cannot wrap at 26 bits.
  localparam int unsigned CHK_W = 26;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/RippleCarryAdder.sv
// Generic ripple-carry adder; carry-out is not exposed.
module RippleCarryAdder #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum
);

  logic [WIDTH-1:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign Sum[i] = A[i] ^ B[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

endmodule

// File: rtl/dma_range_check.sv
// Flags a transfer whose last byte would fall at or beyond MEM_BYTES.
module dma_range_check
  import dma_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned CNT_W     = 8
) (
  input  logic [23:0]      base,
  input  logic [CNT_W-1:0] count,
  output logic             out_of_range
);

  logic [CHK_W-1:0] span;
  logic [CHK_W-1:0] limit;

  assign span         = CHK_W'(count) * CHK_W'(WORD_BYTES);
  assign limit        = CHK_W'(base) + span;
  assign out_of_range = limit > CHK_W'(MEM_BYTES);

endmodule

// File: rtl/data_mem_dma.sv
// Word-copy DMA initiator for the 24-bit data memory port.
// Optional fill mode (Mode/FillData ports) is enabled by defining DMA_FILL_EN.
module data_mem_dma
  import dma_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [23:0]      SrcAddr,
  input  logic [23:0]      DstAddr,
  input  logic [CNT_W-1:0] Count,
`ifdef DMA_FILL_EN
  input  logic             Mode,
  input  logic [23:0]      FillData,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [23:0]      Address,
  output logic [23:0]      WriteData,
  output logic             MemWrite,
  output logic             MemRead,
  input  logic [23:0]      ReadData
);

  state_t           state;
  logic [23:0]      src_ptr, dst_ptr, src_next, dst_next;
  logic [23:0]      word_buf;
  logic [CNT_W-1:0] remaining;
  logic             mem_write_q;
  logic             src_oor, dst_oor, range_err;
  logic             fill_mode;
  logic [23:0]      fill_word;

`ifdef DMA_FILL_EN
  logic        mode_q;
  logic [23:0] fill_q;
  assign fill_mode = mode_q;
  assign fill_word = fill_q;
`else
  assign fill_mode = 1'b0;
  assign fill_word = '0;
`endif

  dma_range_check #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) u_src_check (
    .base         (src_ptr),
    .count        (remaining),
    .out_of_range (src_oor)
  );

  dma_range_check #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) u_dst_check (
    .base         (dst_ptr),
    .count        (remaining),
    .out_of_range (dst_oor)
  );

  RippleCarryAdder #(.WIDTH(24)) u_src_inc (
    .A   (src_ptr),
    .B   (24'(WORD_BYTES)),
    .Cin (1'b0),
    .Sum (src_next)
  );

  RippleCarryAdder #(.WIDTH(24)) u_dst_inc (
    .A   (dst_ptr),
    .B   (24'(WORD_BYTES)),
    .Cin (1'b0),
    .Sum (dst_next)
  );

  // Fill mode never reads, so the source range is irrelevant there.
  assign range_err = dst_oor | (src_oor & ~fill_mode);

  // Gated so a write already scheduled cannot land on the reset edge.
  assign MemWrite  = mem_write_q & ~Reset;
  assign WriteData = word_buf;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
      MemRead     <= 1'b0;
      mem_write_q <= 1'b0;
      Address     <= '0;
      word_buf    <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
`ifdef DMA_FILL_EN
      mode_q      <= 1'b0;
      fill_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            src_ptr   <= SrcAddr;
            dst_ptr   <= DstAddr;
            remaining <= Count;
            Busy      <= 1'b1;
            Error     <= 1'b0;
            state     <= CHECK;
`ifdef DMA_FILL_EN
            mode_q    <= Mode;
            fill_q    <= FillData;
`endif
          end
        end
        CHECK: begin
          if (range_err) begin
            Error <= 1'b1;
            Done  <= 1'b1;
            state <= DONE;
          end else if (remaining == '0) begin
            Done  <= 1'b1;
            state <= DONE;
          end else if (fill_mode) begin
            Address     <= dst_ptr;
            word_buf    <= fill_word;
            mem_write_q <= 1'b1;
            state       <= WRITE;
          end else begin
            Address <= src_ptr;
            MemRead <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          word_buf    <= ReadData;
          Address     <= dst_ptr;
          MemRead     <= 1'b0;
          mem_write_q <= 1'b1;
          state       <= WRITE;
        end
        WRITE: begin
          src_ptr   <= src_next;
          dst_ptr   <= dst_next;
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            mem_write_q <= 1'b0;
            Done        <= 1'b1;
            state       <= DONE;
          end else if (fill_mode) begin
            Address <= dst_next;
          end else begin
            mem_write_q <= 1'b0;
            MemRead     <= 1'b1;
            Address     <= src_next;
            state       <= READ;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
